down_count_monitor: RTL and testbench

- Sits directly downstream of the 4-bit down counter; consumes its `count` output every clock.
- Checks that the stream decrements by exactly 1 per enabled cycle, wrapping from 0 to 2^WIDTH-1.
- Emits a one-cycle pulse on each wrap and keeps saturating wrap and error counters.
- Reports lock status and a sticky sequence-error flag, so the counter can be checked in-system and its period used as a timebase tick.

---
 rtl/down_count_monitor_if.sv | 25 ++
 rtl/down_count_monitor.sv | 109 ++++++++++
 tb/tb_down_count_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/down_count_monitor_if.sv
// Bundles the monitored count stream (in) and the monitor status (out).
interface down_count_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
);
  logic              en;
  logic [WIDTH-1:0]  count_in;
  logic              clr_err;
  logic              locked;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              seq_err;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output en, count_in, clr_err,
    input  locked, wrap_pulse, wrap_count, seq_err, err_count
  );

  modport slave (
    input  en, count_in, clr_err,
    output locked, wrap_pulse, wrap_count, seq_err, err_count
  );
endinterface

// File: rtl/down_count_monitor.sv
// Checks a down-counter stream decrements by one per enabled sample, counts
// wraps and mismatches, and reports lock / sticky error status.
module down_count_monitor #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8,
  parameter int RELOCK = 2
) (
  input  logic               clk,
  input  logic               rst,
  down_count_monitor_if.slave mon
);
  localparam int GOOD_W = 4;

  typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  prev;
  logic [GOOD_W-1:0] good_cnt, good_nxt, good_inc;
  logic [WIDTH-1:0]  expected;
  logic              match, wrap, err_hit;
  logic              locked_nxt, pulse_nxt, seq_nxt;
  logic [WRAP_W-1:0] wc_nxt;
  logic [ERR_W-1:0]  ec_nxt;

  assign expected = prev - 1'b1;
  assign match    = (mon.count_in == expected);
  assign wrap     = (prev == '0) && (&mon.count_in);
  assign good_inc = good_cnt + 1'b1;

  always_comb begin
    state_nxt  = state;
    good_nxt   = good_cnt;
    locked_nxt = mon.locked;
    pulse_nxt  = 1'b0;
    wc_nxt     = mon.wrap_count;
    seq_nxt    = mon.seq_err;
    ec_nxt     = mon.err_count;
    err_hit    = 1'b0;
    if (mon.clr_err) begin
      seq_nxt = 1'b0;
      ec_nxt  = '0;
    end
    if (mon.en) begin
      unique case (state)
        ACQUIRE: begin
          state_nxt  = TRACK;
          locked_nxt = 1'b1;
        end
        TRACK: begin
          if (match) begin
            if (wrap) begin
              pulse_nxt = 1'b1;
              if (!(&mon.wrap_count)) wc_nxt = mon.wrap_count + 1'b1;
            end
          end else begin
            state_nxt  = FAULT;
            locked_nxt = 1'b0;
            good_nxt   = '0;
            err_hit    = 1'b1;
          end
        end
        FAULT: begin
          // wraps while faulted are deliberately not credited
          if (match) begin
            if (good_inc == GOOD_W'(RELOCK)) begin
              state_nxt  = TRACK;
              locked_nxt = 1'b1;
              good_nxt   = '0;
            end else begin
              good_nxt = good_inc;
            end
          end else begin
            good_nxt = '0;
            err_hit  = 1'b1;
          end
        end
        default: state_nxt = ACQUIRE;
      endcase
    end
    // error applied after the clear so a same-cycle mismatch leaves count 1
    if (err_hit) begin
      seq_nxt = 1'b1;
      if (!(&ec_nxt)) ec_nxt = ec_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ACQUIRE;
      prev           <= '0;
      good_cnt       <= '0;
      mon.locked     <= 1'b0;
      mon.wrap_pulse <= 1'b0;
      mon.wrap_count <= '0;
      mon.seq_err    <= 1'b0;
      mon.err_count  <= '0;
    end else begin
      state          <= state_nxt;
      good_cnt       <= good_nxt;
      mon.locked     <= locked_nxt;
      mon.wrap_pulse <= pulse_nxt;
      mon.wrap_count <= wc_nxt;
      mon.seq_err    <= seq_nxt;
      mon.err_count  <= ec_nxt;
      if (mon.en) prev <= mon.count_in;
    end
  end
endmodule

// File: tb/tb_down_count_monitor.sv
// Table vectors, saturation/reset sequences and randomized stimulus checked
// against an arithmetic reference model of the monitor.
module tb_down_count_monitor;
  localparam int WIDTH  = 4;
  localparam int WRAP_W = 8;
  localparam int ERR_W  = 8;
  localparam int RELOCK = 2;
  localparam int M      = 1 << WIDTH;
  localparam int WMAX   = (1 << WRAP_W) - 1;
  localparam int EMAX   = (1 << ERR_W) - 1;
  localparam int OW     = 3 + WRAP_W + ERR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  down_count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) ifc ();

  down_count_monitor #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .ERR_W(ERR_W), .RELOCK(RELOCK)) dut (
    .clk(clk), .rst(rst), .mon(ifc.slave)
  );

  typedef struct {
    logic        en;
    logic [3:0]  cnt;
    logic        clr;
    logic        lk;
    logic        wp;
    logic [7:0]  wc;
    logic        se;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[18];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: acquired flag, last value, tracking flag, good-run length
  bit m_acq, m_locked, m_pulse, m_sticky;
  int m_prev, m_run, m_wraps, m_errs;
  int v;

  function automatic vec_t mk(input logic e, input int c, input logic cl, input logic lk,
                              input logic wp, input int wc, input logic se, input int ec);
    vec_t r;
    r.en = e; r.cnt = 4'(c); r.clr = cl; r.lk = lk; r.wp = wp;
    r.wc = 8'(wc); r.se = se; r.ec = 8'(ec);
    return r;
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {ifc.locked, ifc.wrap_pulse, ifc.wrap_count, ifc.seq_err, ifc.err_count};
  endfunction

  function automatic logic [OW-1:0] model_out();
    return {m_locked, m_pulse, WRAP_W'(m_wraps), m_sticky, ERR_W'(m_errs)};
  endfunction

  task automatic model_reset();
    m_acq = 0; m_locked = 0; m_pulse = 0; m_sticky = 0;
    m_prev = 0; m_run = 0; m_wraps = 0; m_errs = 0;
  endtask

  task automatic model_step(input bit e, input int c, input bit cl);
    bit good;
    m_pulse = 0;
    if (cl) begin m_sticky = 0; m_errs = 0; end
    if (!e) return;
    if (!m_acq) begin
      m_acq = 1; m_locked = 1;
    end else begin
      good = (c == (m_prev + M - 1) % M);
      if (good && m_locked) begin
        if (m_prev == 0 && c == M - 1) begin
          m_pulse = 1;
          if (m_wraps < WMAX) m_wraps++;
        end
      end else if (good) begin
        m_run++;
        if (m_run == RELOCK) begin m_locked = 1; m_run = 0; end
      end else begin
        m_locked = 0; m_run = 0; m_sticky = 1;
        if (m_errs < EMAX) m_errs++;
      end
    end
    m_prev = c;
  endtask

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got lk=%0b wp=%0b wc=%0d se=%0b ec=%0d, want lk=%0b wp=%0b wc=%0d se=%0b ec=%0d",
               name, got[OW-1], got[OW-2], got[OW-3 -: WRAP_W], got[ERR_W], got[ERR_W-1:0],
               exp[OW-1], exp[OW-2], exp[OW-3 -: WRAP_W], exp[ERR_W], exp[ERR_W-1:0]);
    end
  endtask

  // drive one sample, update the model, and settle just after the edge
  task automatic step(input bit e, input int c, input bit cl);
    ifc.en = e; ifc.count_in = WIDTH'(c); ifc.clr_err = cl;
    model_step(e, c, cl);
    if (e) v = c;
    @(posedge clk); #1;
  endtask

  task automatic step_chk(input string name, input bit e, input int c, input bit cl);
    step(e, c, cl);
    check(name, dut_out(), model_out());
  endtask

  initial begin
    tbl[0]  = mk(1,  3, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1,  2, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1,  1, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1,  0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 15, 0, 1, 1, 1, 0, 0);
    tbl[5]  = mk(1, 14, 0, 1, 0, 1, 0, 0);
    tbl[6]  = mk(0,  9, 0, 1, 0, 1, 0, 0);
    tbl[7]  = mk(1, 13, 0, 1, 0, 1, 0, 0);
    tbl[8]  = mk(1, 10, 0, 0, 0, 1, 1, 1);
    tbl[9]  = mk(1,  9, 0, 0, 0, 1, 1, 1);
    tbl[10] = mk(1,  9, 0, 0, 0, 1, 1, 2);
    tbl[11] = mk(1,  8, 0, 0, 0, 1, 1, 2);
    tbl[12] = mk(1,  7, 0, 1, 0, 1, 1, 2);
    tbl[13] = mk(1,  1, 1, 0, 0, 1, 1, 1);
    tbl[14] = mk(1,  0, 0, 0, 0, 1, 1, 1);
    tbl[15] = mk(1, 15, 0, 1, 0, 1, 1, 1);
    tbl[16] = mk(1, 14, 1, 1, 0, 1, 0, 0);
    tbl[17] = mk(1, 13, 0, 1, 0, 1, 0, 0);

    ifc.en = 0; ifc.count_in = '0; ifc.clr_err = 0; v = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_out(), '0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].en, int'(tbl[i].cnt), tbl[i].clr);
      check($sformatf("vec%0d", i), dut_out(),
            {tbl[i].lk, tbl[i].wp, tbl[i].wc, tbl[i].se, tbl[i].ec});
    end

    // 300 wraps of a clean stream: wrap_count saturates, pulses keep firing
    for (int i = 0; i < 300 * M; i++) step_chk("wrap_sat", 1, (v + M - 1) % M, 0);
    check("wrap_count_max", dut_out(), {1'b1, 1'b0, WRAP_W'(WMAX), 1'b0, ERR_W'(0)});

    // stalled counter: every repeat is a mismatch until err_count saturates
    for (int i = 0; i < 260; i++) step_chk("err_sat", 1, v, 0);
    check("err_count_max", dut_out(), {1'b0, 1'b0, WRAP_W'(WMAX), 1'b1, ERR_W'(EMAX)});
    step_chk("clr_idle", 0, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      bit e, cl;
      int c;
      e  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 31) == 0);
      c  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, M - 1)) : (v + M - 1) % M;
      if (!e) c = int'($urandom_range(0, M - 1));
      step_chk("random", e, c, cl);
    end

    // land on a wrap while locked, then reset with the pulse in flight
    for (int i = 0; i < 4 * M; i++) begin
      step_chk("pre_reset", 1, (v + M - 1) % M, 0);
      if (i > 4 && v == M - 1) break;
    end
    check("pulse_before_reset", {31'b0, ifc.wrap_pulse}, 32'd1);
    #2 rst = 1'b0;
    #1 check("async_reset", dut_out(), '0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step_chk("post_reset_7", 1, 7, 0);
    step_chk("post_reset_6", 1, 6, 0);
    check("post_reset_locked", dut_out(), {1'b1, 1'b0, WRAP_W'(0), 1'b0, ERR_W'(0)});
    for (int i = 0; i < 5; i++) step_chk("en_low_hold", 0, int'($urandom_range(0, M - 1)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
